// File: rtl/i2s_master_receiver.sv
// I2S master receiver: generates sck/ws from clk and shifts in MSB-first samples
// with the one-bit I2S delay, emitting one valid pulse per enabled channel per frame.
module i2s_master_receiver #(
  parameter int unsigned SCK_DIV_LOG2 = 3,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned SAMPLE_BITS  = 24,
  parameter logic [1:0]  CH_EN        = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sd,
  output logic                   sck,
  output logic                   ws,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   sample_right,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam int unsigned PH_W  = SCK_DIV_LOG2 + 1;
  localparam int unsigned HALF  = 2 ** SCK_DIV_LOG2;
  localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  localparam logic [PH_W-1:0]  PH_STROBE   = PH_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SAMPLE_LAST = BIT_W'(SAMPLE_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   slot_q, slot_d;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  logic [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic                   right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic                   ph_wrap, frame_end, strobe;

  // The phase counter spans exactly P = 2*HALF states, so it wraps on its own.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    slot_d    = slot_q;
    shreg_d   = shreg_q;
    ph_wrap   = &ph_q;
    frame_end = ph_wrap && slot_q && (bit_q == BIT_LAST);
    strobe    = (state_q != IDLE) && (ph_q == PH_STROBE);

    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = frame_end ? IDLE : DRAIN;
      DRAIN:   if (enable) state_d = RUN;
               else if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      ph_d = ph_q + 1'b1;
      if (ph_wrap) begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        if (bit_q == BIT_LAST) slot_d = ~slot_q;
      end
    end
    if (state_d == IDLE) begin
      ph_d   = '0;
      bit_d  = '0;
      slot_d = 1'b0;
    end

    // ws leads the slot MSB by one bit: high from the last left bit to the second-last right bit.
    sck_d = ph_d[PH_W-1];
    ws_d  = (state_d != IDLE) && (slot_d ? (bit_d != BIT_LAST) : (bit_d == BIT_LAST));

    if (strobe && (bit_q <= SAMPLE_LAST)) shreg_d = SAMPLE_BITS'({shreg_q, sd});

    valid_d  = strobe && (bit_q == SAMPLE_LAST) && CH_EN[slot_q];
    sample_d = valid_d ? shreg_d : sample_q;
    right_d  = valid_d ? slot_q : right_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      slot_q   <= 1'b0;
      shreg_q  <= '0;
      sample_q <= '0;
      right_q  <= 1'b0;
      valid_q  <= 1'b0;
      sck_q    <= 1'b0;
      ws_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
      sck_q    <= sck_d;
      ws_q     <= ws_d;
    end
  end

  assign sck          = sck_q;
  assign ws           = ws_q;
  assign sample       = sample_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule
